// File: rtl/fifos_pkg.sv
// Shared definitions for the single-clock FIFO family: read-FSM states and
// beat-geometry helpers used by stream readers.
package fifos_pkg;

  typedef enum logic [0:0] {
    RD_IDLE  = 1'b0,
    RD_BEATS = 1'b1
  } rd_state_e;

  function automatic int beats_per_word(input int wid, input int owid);
    return (owid > 0) ? wid / owid : 1;
  endfunction

  // A single-beat word still needs a 1-bit index so the datapath stays uniform.
  function automatic int beat_width(input int wid, input int owid);
    int r;
    r = beats_per_word(wid, owid);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

  function automatic bit width_ok(input int wid, input int owid);
    return (owid > 0) && ((wid % owid) == 0);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus narrow valid/ready output stream of the stream reader.
interface fifo_stream_reader_if #(
  parameter int WID  = 32,
  parameter int OWID = 8,
  parameter int AWID = 3
);
  logic            fifo_empty;
  logic [AWID:0]   fifo_count;
  logic [WID-1:0]  fifo_dataout;
  logic            fifo_readout;
  logic            out_valid;
  logic [OWID-1:0] out_data;
  logic            out_last;
  logic            out_ready;

  modport master (
    input  fifo_empty, fifo_count, fifo_dataout, out_ready,
    output fifo_readout, out_valid, out_data, out_last
  );

  modport slave (
    output fifo_empty, fifo_count, fifo_dataout, out_ready,
    input  fifo_readout, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fifo_head_guard.sv
// Tells a FIFO reader when the registered head word is valid to consume,
// masking the stale cycle after a write into an empty FIFO or a count-1 pop.
module fifo_head_guard #(
  parameter int AWID = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          softreset,
  input  logic          fifo_empty,
  input  logic [AWID:0] fifo_count,
  input  logic          fifo_readout,
  output logic          head_usable
);
  logic head_ok_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ok_q <= 1'b0;
    end else if (softreset) begin
      head_ok_q <= 1'b0;
    end else begin
      head_ok_q <= !fifo_empty && !(fifo_readout && (fifo_count == (AWID+1)'(1)));
    end
  end

  assign head_usable = head_ok_q && !fifo_empty;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops words from a registered-head FIFO and serializes each into WID/OWID
// narrow beats on a valid/ready stream.
module fifo_stream_reader
  import fifos_pkg::*;
#(
  parameter int WID       = 32,
  parameter int OWID      = 8,
  parameter int AWID      = 3,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 softreset,
  fifo_stream_reader_if.master bus,
  output logic                 busy
);
  localparam int R  = beats_per_word(WID, OWID);
  localparam int BW = beat_width(WID, OWID);
  localparam logic [BW-1:0] LAST_BEAT = BW'(R - 1);

  if (!width_ok(WID, OWID)) begin : g_width_check
    $error("fifo_stream_reader: WID must be an integer multiple of OWID");
  end

  rd_state_e      state_reg, state_next;
  logic [WID-1:0] hold_reg, hold_next;
  logic [BW-1:0]  beat_reg, beat_next;
  logic [BW-1:0]  slice_sel;
  logic           head_usable;
  logic           accept;

  fifo_head_guard #(.AWID(AWID)) u_head_guard (
    .clk         (clk),
    .rst_n       (rst_n),
    .softreset   (softreset),
    .fifo_empty  (bus.fifo_empty),
    .fifo_count  (bus.fifo_count),
    .fifo_readout(bus.fifo_readout),
    .head_usable (head_usable)
  );

  assign bus.out_valid = (state_reg == RD_BEATS);
  assign bus.out_last  = bus.out_valid && (beat_reg == LAST_BEAT);
  assign accept        = bus.out_valid && bus.out_ready;

  // Refill either from idle or on the last-beat accept, so words stream back to back.
  assign bus.fifo_readout = head_usable && !softreset &&
                            ((state_reg == RD_IDLE) || (accept && bus.out_last));

  assign slice_sel    = MSB_FIRST ? (LAST_BEAT - beat_reg) : beat_reg;
  assign bus.out_data = bus.out_valid ? hold_reg[slice_sel*OWID +: OWID] : '0;
  assign busy         = bus.out_valid || !bus.fifo_empty;

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    beat_next  = beat_reg;
    if (bus.fifo_readout) begin
      hold_next  = bus.fifo_dataout;
      beat_next  = '0;
      state_next = RD_BEATS;
    end else if (accept) begin
      if (bus.out_last) begin
        state_next = RD_IDLE;
      end else begin
        beat_next = beat_reg + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RD_IDLE;
      hold_reg  <= '0;
      beat_reg  <= '0;
    end else if (softreset) begin
      state_reg <= RD_IDLE;
      hold_reg  <= '0;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
      beat_reg  <= beat_next;
    end
  end

  a_no_pop_when_empty: assert property (
    @(posedge clk) disable iff (!rst_n) !(bus.fifo_readout && bus.fifo_empty)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench: three reader configs (LSB-first x8, MSB-first x8, single-beat x32),
// each fed by a small registered-head FIFO model of depth 8.
module tb_fifo_stream_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic softreset = 1'b0;
  always #5 clk = ~clk;

  logic        wr_en   [3];
  logic [31:0] wr_data [3];
  logic        rdy     [3];
  logic        ov  [3];
  logic        ol  [3];
  logic        rdo [3];
  logic        by  [3];
  logic        fe  [3];
  logic [31:0] od  [3];
  logic [3:0]  fc  [3];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_d [$];
  logic        exp_l [$];
  logic [31:0] wq    [$];

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_dut
    localparam int OW = (gi == 2) ? 32 : 8;
    localparam bit MF = (gi == 1);

    fifo_stream_reader_if #(.WID(32), .OWID(OW), .AWID(3)) bus ();

    logic [31:0] mem [8];
    logic [3:0]  cnt;
    logic [2:0]  wp, rp, rp_next;
    logic [31:0] dout;
    logic        busy_w, do_wr, do_rd;

    assign do_wr   = wr_en[gi] && (cnt != 4'd8);
    assign do_rd   = bus.fifo_readout;
    assign rp_next = rp + 3'(do_rd);

    // Head register reads the post-pop address; a same-edge write is not yet visible.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0; wp <= '0; rp <= '0; dout <= '0;
      end else if (softreset) begin
        cnt <= '0; wp <= '0; rp <= '0; dout <= '0;
      end else begin
        if (do_wr) begin
          mem[wp] <= wr_data[gi];
          wp <= wp + 3'd1;
        end
        rp   <= rp_next;
        dout <= mem[rp_next];
        cnt  <= cnt + 4'(do_wr) - 4'(do_rd);
      end
    end

    assign bus.fifo_empty   = (cnt == 4'd0);
    assign bus.fifo_count   = cnt;
    assign bus.fifo_dataout = dout;
    assign bus.out_ready    = rdy[gi];

    assign ov[gi]  = bus.out_valid;
    assign ol[gi]  = bus.out_last;
    assign od[gi]  = 32'(bus.out_data);
    assign rdo[gi] = bus.fifo_readout;
    assign by[gi]  = busy_w;
    assign fe[gi]  = bus.fifo_empty;
    assign fc[gi]  = cnt;

    fifo_stream_reader #(.WID(32), .OWID(OW), .AWID(3), .MSB_FIRST(MF)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .softreset(softreset),
      .bus      (bus.master),
      .busy     (busy_w)
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected beats of one word for reader d.
  task automatic push_word(input int d, input logic [31:0] w);
    int ow, r, idx;
    logic [31:0] m;
    ow = (d == 2) ? 32 : 8;
    r  = 32 / ow;
    m  = (ow == 32) ? 32'hFFFF_FFFF : ((32'd1 << ow) - 32'd1);
    for (int i = 0; i < r; i++) begin
      idx = (d == 1) ? (r - 1 - i) : i;
      exp_d.push_back((w >> (idx * ow)) & m);
      exp_l.push_back(i == r - 1);
    end
  endtask

  // Feeds wq into FIFO d and checks every presented beat against the scoreboard.
  task automatic drain(input int d, input int pct, input int budget,
                       output int pops, output int span);
    int first, last, n;
    first = -1; last = -1; n = 0; pops = 0;
    while (n < budget) begin
      rdy[d] = ($urandom_range(0, 99) < pct);
      if (wq.size() > 0 && fc[d] < 4'd8) begin
        wr_en[d] = 1'b1;
        wr_data[d] = wq.pop_front();
      end else begin
        wr_en[d] = 1'b0;
      end
      #1;
      if (rdo[d]) pops++;
      if (ov[d] && !(rdy[d] && ol[d])) check("no_pop_mid_word", 32'(rdo[d]), 0);
      if (ov[d]) begin
        if (exp_d.size() == 0) begin
          check("extra_beat", 32'(ov[d]), 0);
        end else begin
          check("beat_data", od[d], exp_d[0]);
          check("beat_last", 32'(ol[d]), 32'(exp_l[0]));
          if (rdy[d]) begin
            $display("dut%0d beat %h last=%0b cycle %0d", d, od[d], ol[d], cyc);
            void'(exp_d.pop_front());
            void'(exp_l.pop_front());
            if (first < 0) first = cyc;
            last = cyc;
          end
        end
      end
      n++;
      if (exp_d.size() == 0 && wq.size() == 0) break;
      step();
    end
    wr_en[d] = 1'b0;
    check("drain_timeout", exp_d.size(), 0);
    span = last - first + 1;
    exp_d.delete();
    exp_l.delete();
    wq.delete();
  endtask

  // Single word 0x44332211, cycles t+1..t+7 after the write cycle.
  localparam logic        SW_V    [7] = '{0, 0, 1, 1, 1, 1, 0};
  localparam logic        SW_RD   [7] = '{0, 1, 0, 0, 0, 0, 0};
  localparam logic [31:0] SW_D    [7] = '{0, 0, 32'h11, 32'h22, 32'h33, 32'h44, 0};
  localparam logic        SW_L    [7] = '{0, 0, 0, 0, 0, 1, 0};
  localparam logic        SW_BUSY [7] = '{1, 1, 1, 1, 1, 1, 0};

  initial begin
    int pops, span, pulses;
    for (int d = 0; d < 3; d++) begin
      wr_en[d] = 1'b0; wr_data[d] = '0; rdy[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_valid", 32'(ov[d]), 0);
      check("rst_data", od[d], 0);
      check("rst_last", 32'(ol[d]), 0);
      check("rst_readout", 32'(rdo[d]), 0);
      check("rst_busy", 32'(by[d]), 0);
    end
    rst_n = 1'b1;
    step();

    // Single word latency and beat order
    rdy[0] = 1'b1; wr_en[0] = 1'b1; wr_data[0] = 32'h4433_2211;
    step();
    wr_en[0] = 1'b0;
    pulses = 0;
    for (int k = 0; k < 7; k++) begin
      #1;
      if (rdo[0]) pulses++;
      check("sw_valid", 32'(ov[0]), 32'(SW_V[k]));
      check("sw_readout", 32'(rdo[0]), 32'(SW_RD[k]));
      check("sw_busy", 32'(by[0]), 32'(SW_BUSY[k]));
      if (SW_V[k]) begin
        check("sw_data", od[0], SW_D[k]);
        check("sw_last", 32'(ol[0]), 32'(SW_L[k]));
      end
      step();
    end
    check("sw_pops", pulses, 1);

    // Burst of 8 words, ready held high
    for (int k = 0; k < 8; k++) begin
      wq.push_back(32'h0302_0100 + k * 32'h0404_0404);
      push_word(0, 32'h0302_0100 + k * 32'h0404_0404);
    end
    drain(0, 100, 200, pops, span);
    check("burst_span", span, 32);
    check("burst_pops", pops, 8);
    check("burst_empty_end", 32'(fe[0]), 1);
    step();
    check("burst_busy_drop", 32'(by[0]), 0);
    check("burst_valid_drop", 32'(ov[0]), 0);

    // Backpressure at 30% ready
    for (int k = 0; k < 6; k++) begin
      wq.push_back(32'h9000_0000 ^ (k * 32'h1357_9BDF));
      push_word(0, 32'h9000_0000 ^ (k * 32'h1357_9BDF));
    end
    drain(0, 30, 2000, pops, span);
    check("bp_pops", pops, 6);
    rdy[0] = 1'b1;
    step();

    // Count-1 hazard, 4 beats per word
    wr_en[0] = 1'b1; wr_data[0] = 32'hA0A1_A2A3;
    step();
    wr_en[0] = 1'b0;
    step();
    wr_en[0] = 1'b1; wr_data[0] = 32'hB0B1_B2B3;
    #1;
    check("hz_pop_at_count1", 32'(rdo[0]), 1);
    step();
    wr_en[0] = 1'b0;
    push_word(0, 32'hA0A1_A2A3);
    push_word(0, 32'hB0B1_B2B3);
    drain(0, 100, 50, pops, span);
    check("hz_span", span, 8);
    step();

    // MSB-first ordering
    rdy[1] = 1'b1;
    wq.push_back(32'hA1B2_C3D4); push_word(1, 32'hA1B2_C3D4);
    wq.push_back(32'h0102_0304); push_word(1, 32'h0102_0304);
    drain(1, 100, 50, pops, span);
    check("msb_span", span, 8);
    check("msb_pops", pops, 2);
    step();

    // Single-beat words
    rdy[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wq.push_back(32'h1111_0000 + k);
      push_word(2, 32'h1111_0000 + k);
    end
    drain(2, 100, 50, pops, span);
    check("r1_span", span, 4);
    check("r1_pops", pops, 4);
    step();

    // Count-1 hazard, single-beat: exactly one bubble
    wr_en[2] = 1'b1; wr_data[2] = 32'hCAFE_F00D;
    step();
    wr_en[2] = 1'b0;
    step();
    wr_en[2] = 1'b1; wr_data[2] = 32'h1234_5678;
    #1;
    check("hz1_pop_a", 32'(rdo[2]), 1);
    step();
    wr_en[2] = 1'b0;
    #1;
    check("hz1_valid_a", 32'(ov[2]), 1);
    check("hz1_data_a", od[2], 32'hCAFE_F00D);
    check("hz1_last_a", 32'(ol[2]), 1);
    check("hz1_no_pop_stale", 32'(rdo[2]), 0);
    step();
    #1;
    check("hz1_bubble", 32'(ov[2]), 0);
    check("hz1_pop_b", 32'(rdo[2]), 1);
    step();
    #1;
    check("hz1_valid_b", 32'(ov[2]), 1);
    check("hz1_data_b", od[2], 32'h1234_5678);
    check("hz1_last_b", 32'(ol[2]), 1);
    step();
    #1;
    check("hz1_idle", 32'(ov[2]), 0);
    check("hz1_busy", 32'(by[2]), 0);
    step();

    // softreset in the cycle a pop would be issued from idle
    wr_en[0] = 1'b1; wr_data[0] = 32'h5555_AAAA;
    step();
    wr_en[0] = 1'b0;
    step();
    softreset = 1'b1;
    #1;
    check("srst_no_pop_idle", 32'(rdo[0]), 0);
    step();
    softreset = 1'b0;
    #1;
    check("srst_idle_valid", 32'(ov[0]), 0);
    check("srst_idle_busy", 32'(by[0]), 0);
    step();

    // softreset on beat 2 with three words queued
    for (int k = 0; k < 4; k++) begin
      wr_en[0] = 1'b1; wr_data[0] = 32'hD3D2_D1D0 + k * 32'h1010_1010;
      if (k == 3) begin
        #1;
        check("srst_b0_valid", 32'(ov[0]), 1);
        check("srst_b0_data", od[0], 32'hD0);
      end
      step();
    end
    wr_en[0] = 1'b0;
    step();
    #1;
    check("srst_b2_valid", 32'(ov[0]), 1);
    check("srst_b2_data", od[0], 32'hD2);
    softreset = 1'b1;
    #1;
    check("srst_no_pop", 32'(rdo[0]), 0);
    step();
    softreset = 1'b0;
    #1;
    check("srst_valid_clear", 32'(ov[0]), 0);
    check("srst_busy_clear", 32'(by[0]), 0);
    check("srst_fifo_empty", 32'(fe[0]), 1);
    step();
    check("srst_stays_idle", 32'(ov[0]), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side companion for the single-clock FIFO. Pops words from the FIFO's registered-head read port and serializes each WID-bit word into WID/OWID narrower beats on a valid/ready output stream. Sits between a buffering FIFO and a narrow downstream consumer, such as a byte-wide link or CSR pipe. Owns the FIFO's `readout` strobe and hides the FIFO's head-data latency from the consumer.

## Interface
- WID, 32, FIFO word width; must be an integer multiple of OWID
- OWID, 8, output beat width
- AWID, 3, FIFO address width; `fifo_count` is AWID+1 bits
- MSB_FIRST, 0, 0: beat 0 = bits [OWID-1:0]; 1: beat 0 = bits [WID-1:WID-OWID]
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- softreset  in  1  synchronous clear of all state; tie to the FIFO's softreset
- fifo_empty  in  1  FIFO empty flag
- fifo_count  in  AWID+1  FIFO occupancy
- fifo_dataout  in  WID  FIFO registered head word
- fifo_readout  out  1  pop strobe to the FIFO (combinational)
- out_valid  out  1  beat available
- out_data  out  OWID  beat payload
- out_last  out  1  last beat of the current word
- out_ready  in  1  consumer accepts the beat
- busy  out  1  word held or FIFO head pending

## Operation
- R = WID/OWID. Beat index `beat` is $clog2(R) bits wide, or 1 bit when R=1.
- Head guard: `head_ok_q` is registered as `!fifo_empty && !(fifo_readout && fifo_count==1)`.
  - The FIFO head is usable in a cycle only when `head_ok_q && !fifo_empty`.
  - This covers the one-cycle stale head after a write into an empty FIFO.
  - It also covers a pop at count 1 that coincides with a write.
- FSM states: RD_IDLE (no word held) and RD_BEATS (word in `hold`, `beat` selects the output slice).
- `fifo_readout = head_usable && (state==RD_IDLE || (out_valid && out_ready && out_last))`.
- On `fifo_readout`:
  - `hold <= fifo_dataout`
  - `beat <= 0`
  - state becomes or stays RD_BEATS
- On an accepted beat that is not the last beat: `beat <= beat+1`.
- On an accepted last beat with no pop: state goes to RD_IDLE.
- `out_valid = (state==RD_BEATS)`.
- `out_data` is the slice of `hold` selected by `beat` and MSB_FIRST.
- `out_last = out_valid && beat==R-1`.
- Stream rule: while `out_valid && !out_ready`, `out_data` and `out_last` hold stable. `out_valid` never drops without an accept.
- `busy = out_valid || !fifo_empty`.
- softreset: state goes to RD_IDLE; `beat`, `hold` and `head_ok_q` go to 0. No pop occurs in the softreset cycle.
- R=1: every beat is last; the block becomes a FIFO-to-valid/ready adapter.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_last=0, busy reflects fifo_empty only
  - fifo_readout=0, because head_ok_q=0
  - state RD_IDLE, hold=0, beat=0
- Latency: a word written into the empty FIFO at edge t appears as beat 0 on `out_valid` at cycle t+3. The pop is issued at cycle t+2.
- Throughput: with fifo_count≥2 and out_ready held high, R beats per word with no bubble between words (pop on the last-beat accept).
- Pop at fifo_count==1 produces exactly one bubble cycle of head guard before the next pop, if a write arrived meanwhile.
- Simultaneous accept of the last beat and pop: the next cycle shows the new word's beat 0 with out_valid still high.
- rst_n asserted mid-word: the held word is discarded and the FIFO is not popped again. The FIFO is reset alongside.
- Never pops when fifo_empty=1 (assertion).

## Structure
- Shared `fifos_pkg` holds:
  - the read-FSM state enum {RD_IDLE, RD_BEATS}
  - a constant function computing R and beat width
  - an elaboration check that WID % OWID == 0
- One sub-module, `fifo_head_guard` (clk, rst_n, softreset, fifo_empty, fifo_count, fifo_readout → head_usable). Any other reader of the FIFO reuses it.
- A bench wrapper instantiates the FIFO (WID=32, DEPTH=8) plus this block.

## Test plan
- Single word: write 0x44332211 into the empty FIFO, out_ready=1 → beats 0x11,0x22,0x33,0x44 on cycles t+3..t+6; out_last only on 0x44; one fifo_readout pulse.
- Burst: write 8 words back-to-back, out_ready=1 → 32 contiguous beats, no bubbles after the first, fifo_empty at the end, busy drops one cycle after the last accept.
- Backpressure: random out_ready at 30% duty → out_data and out_last stable while stalled; beat order matches a scoreboard; no pop while a word has unaccepted beats.
- Count-1 hazard: a FIFO holding one word receives a write in the same cycle as the pop → the second word is emitted correctly (not stale) after one bubble.
- MSB_FIRST=1, word 0xA1B2C3D4 → beats 0xA1,0xB2,0xC3,0xD4; R=1 config (OWID=32) → one beat per word, out_last always high.
- softreset asserted on beat 2 of a word with 3 words queued → out_valid=0 the next cycle; no fifo_readout in the softreset cycle; after release with the FIFO also cleared, busy=0.
